encode_instruction_loader: RTL and testbench

Inverse of the instruction decoder. Accepts instruction fields over a valid/ready stream and packs each set into one instruction word. Writes the packed words sequentially into instruction memory from a programmable base address. Sits between the testbench or boot loader and the instruction memory write port; a 2-entry buffer decouples the input stream from memory back-pressure.

---
 rtl/encode_instruction_loader.sv | 138 +++++++++++++
 tb/tb_encode_instruction_loader.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/encode_instruction_loader.sv
// Packs decoded instruction fields into 16-bit words and writes them
// sequentially into instruction memory from a programmable base address.
// A 2-entry FIFO sits between the field stream and the memory write port.
module encode_instruction_loader #(
  parameter int WORD_SIZE      = 16,
  parameter int OPCODE_SIZE    = 4,
  parameter int REG_ADDR_SIZE  = 4,
  parameter int SMALL_IMM_SIZE = 4,
  parameter int BIG_IMM_SIZE   = 8,
  parameter int MEM_ADDR_SIZE  = 8
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      start,
  input  logic [MEM_ADDR_SIZE-1:0]  base_addr,
  input  logic [MEM_ADDR_SIZE:0]    count,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [OPCODE_SIZE-1:0]    in_opcode,
  input  logic [REG_ADDR_SIZE-1:0]  in_reg_dest,
  input  logic [REG_ADDR_SIZE-1:0]  in_reg_src,
  input  logic [SMALL_IMM_SIZE-1:0] in_small_imm,
  input  logic [BIG_IMM_SIZE-1:0]   in_big_imm,
  input  logic                      in_use_big,
  output logic                      mem_we,
  input  logic                      mem_ready,
  output logic [MEM_ADDR_SIZE-1:0]  mem_addr,
  output logic [WORD_SIZE-1:0]      mem_wdata,
  output logic                      busy,
  output logic                      done,
  output logic [MEM_ADDR_SIZE:0]    written
);

  typedef enum logic [1:0] {ST_IDLE, ST_LOAD, ST_DONE} state_t;

  localparam logic [MEM_ADDR_SIZE:0] CNT_ONE = 1;

  state_t                   state, state_next;
  logic [WORD_SIZE-1:0]     fifo_mem [2];
  logic                     wr_ptr, rd_ptr;
  logic [1:0]               fifo_cnt;
  logic                     fifo_full, fifo_empty;
  logic                     push, pop, last_pop;
  logic [MEM_ADDR_SIZE-1:0] base_q;
  logic [MEM_ADDR_SIZE:0]   count_q, accepted, written_q;
  logic [WORD_SIZE-1:0]     packed_word;

  // Pack the field set; the big immediate overlays the src and small immediate slots.
  always_comb begin
    if (in_use_big) packed_word = {in_opcode, in_reg_dest, in_big_imm};
    else            packed_word = {in_opcode, in_reg_dest, in_reg_src, in_small_imm};
  end

  assign fifo_full  = (fifo_cnt == 2'd2);
  assign fifo_empty = (fifo_cnt == 2'd0);
  assign mem_we     = !fifo_empty;
  assign mem_wdata  = fifo_mem[rd_ptr];
  assign mem_addr   = base_q + written_q[MEM_ADDR_SIZE-1:0];
  assign written    = written_q;
  assign push       = in_valid && in_ready;
  assign pop        = mem_we && mem_ready;
  assign last_pop   = pop && ((written_q + CNT_ONE) == count_q);

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    // NOTE: sequential state always uses non-blocking assignments so every
    // flop samples pre-edge values regardless of block evaluation order.
    if (reset) state <= ST_IDLE;
    else       state <= state_next;
  end

  // Next-state and state-decoded outputs.
  always_comb begin
    // NOTE: every output gets a default first, so no path leaves a latch.
    state_next = state;
    in_ready   = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start) state_next = (count == '0) ? ST_DONE : ST_LOAD;
      end
      ST_LOAD: begin
        busy     = 1'b1;
        in_ready = !fifo_full && (accepted < count_q);
        if (last_pop) state_next = ST_DONE;
      end
      ST_DONE: begin
        done       = 1'b1;
        state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // Load parameters and progress counters; start clears them only from IDLE.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      base_q    <= '0;
      count_q   <= '0;
      accepted  <= '0;
      written_q <= '0;
    end else if (state == ST_IDLE && start) begin
      base_q    <= base_addr;
      count_q   <= count;
      accepted  <= '0;
      written_q <= '0;
    end else begin
      if (push) accepted  <= accepted + CNT_ONE;
      if (pop)  written_q <= written_q + CNT_ONE;
    end
  end

  // Two-entry FIFO between the packer and the memory write port.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      // NOTE: the two storage words are reset so mem_wdata reads zero after
      // reset instead of X; at this depth the cost is negligible.
      fifo_mem[0] <= '0;
      fifo_mem[1] <= '0;
      wr_ptr      <= 1'b0;
      rd_ptr      <= 1'b0;
      fifo_cnt    <= 2'd0;
    end else begin
      if (push) begin
        fifo_mem[wr_ptr] <= packed_word;
        wr_ptr           <= ~wr_ptr;
      end
      if (pop) rd_ptr <= ~rd_ptr;
      case ({push, pop})
        2'b10:   fifo_cnt <= fifo_cnt + 2'd1;
        2'b01:   fifo_cnt <= fifo_cnt - 2'd1;
        default: fifo_cnt <= fifo_cnt;
      endcase
    end
  end

endmodule

// File: tb/tb_encode_instruction_loader.sv
// Randomized bench for encode_instruction_loader: a transaction-level model
// (queue of expected words, write/accept counts) is checked every cycle,
// plus literal checks for the directed scenarios.
module tb_encode_instruction_loader;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [7:0]  base_addr;
  logic [8:0]  count;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  in_opcode, in_reg_dest, in_reg_src, in_small_imm;
  logic [7:0]  in_big_imm;
  logic        in_use_big;
  logic        mem_we;
  logic        mem_ready;
  logic [7:0]  mem_addr;
  logic [15:0] mem_wdata;
  logic        busy, done;
  logic [8:0]  written;

  int checks   = 0;
  int failures = 0;

  // Reference model state.
  bit          m_load = 0, m_done = 0;
  int          m_base = 0, m_count = 0, m_acc = 0, m_wr = 0;
  int          exp_q[$];
  logic [23:0] log_q[$];

  logic rdy_force = 1'b1;
  bit   rand_rdy  = 0;

  encode_instruction_loader dut (
    .clk(clk), .reset(reset), .start(start), .base_addr(base_addr), .count(count),
    .in_valid(in_valid), .in_ready(in_ready), .in_opcode(in_opcode),
    .in_reg_dest(in_reg_dest), .in_reg_src(in_reg_src), .in_small_imm(in_small_imm),
    .in_big_imm(in_big_imm), .in_use_big(in_use_big), .mem_we(mem_we),
    .mem_ready(mem_ready), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .busy(busy), .done(done), .written(written)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int pack_fields(int op, int d, int s, int si, int bi, bit ub);
    return op * 4096 + d * 256 + (ub ? bi : s * 16 + si);
  endfunction

  // Memory ready: forced level or random, changed just after each rising edge.
  always @(posedge clk) begin
    #1;
    mem_ready = rand_rdy ? 1'($urandom_range(0, 1)) : rdy_force;
  end

  // Cycle monitor: compare against the model, then advance the model across the next edge.
  always @(negedge clk) begin
    bit exp_rdy, exp_we, was_idle, was_done;
    if (reset) begin
      m_load = 0; m_done = 0; m_base = 0; m_count = 0; m_acc = 0; m_wr = 0;
      exp_q.delete();
    end else begin
      exp_rdy = m_load && (exp_q.size() < 2) && (m_acc < m_count);
      exp_we  = (exp_q.size() != 0);
      check("in_ready", in_ready, exp_rdy);
      check("mem_we", mem_we, exp_we);
      check("busy", busy, m_load);
      check("done", done, m_done);
      check("written", written, m_wr);
      if (exp_we) begin
        check("mem_addr", mem_addr, (m_base + m_wr) % 256);
        check("mem_wdata", mem_wdata, exp_q[0]);
      end
      was_idle = !m_load && !m_done;
      was_done = m_done;
      if (was_done) m_done = 0;
      if (exp_we && mem_ready) begin
        log_q.push_back({mem_addr, mem_wdata});
        void'(exp_q.pop_front());
        m_wr++;
        if (m_wr == m_count) begin m_load = 0; m_done = 1; end
      end
      if (in_valid && exp_rdy) begin
        exp_q.push_back(pack_fields(in_opcode, in_reg_dest, in_reg_src, in_small_imm,
                                    in_big_imm, in_use_big));
        m_acc++;
      end
      if (was_idle && start) begin
        m_base = base_addr; m_count = count; m_acc = 0; m_wr = 0;
        if (count == 0) m_done = 1;
        else            m_load = 1;
      end
    end
  end

  task automatic do_start(input logic [7:0] b, input logic [8:0] c);
    @(posedge clk); #1;
    base_addr = b; count = c; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic send(input logic [3:0] op, input logic [3:0] d, input logic [3:0] s,
                      input logic [3:0] si, input logic [7:0] bi, input logic ub);
    bit ok = 0;
    @(posedge clk); #1;
    in_opcode = op; in_reg_dest = d; in_reg_src = s; in_small_imm = si;
    in_big_imm = bi; in_use_big = ub; in_valid = 1'b1;
    for (int i = 0; i < 100 && !ok; i++) begin
      @(negedge clk);
      if (in_ready) ok = 1;
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    if (!ok) check("send_timeout", 0, 1);
  endtask

  task automatic send_rand();
    send(4'($urandom), 4'($urandom), 4'($urandom), 4'($urandom), 8'($urandom), 1'($urandom));
  endtask

  task automatic wait_done(input int limit);
    bit ok = 0;
    for (int i = 0; i < limit && !ok; i++) begin
      @(negedge clk);
      if (done) ok = 1;
    end
    if (!ok) check("done_timeout", 0, 1);
  endtask

  task automatic wait_writes(input int n);
    bit ok = 0;
    for (int i = 0; i < 200 && !ok; i++) begin
      @(negedge clk);
      if (log_q.size() >= n) ok = 1;
    end
    if (!ok) check("write_timeout", 0, 1);
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; base_addr = '0; count = '0; in_valid = 1'b0;
    in_opcode = '0; in_reg_dest = '0; in_reg_src = '0; in_small_imm = '0;
    in_big_imm = '0; in_use_big = 1'b0; mem_ready = 1'b1;
    #1;
    check("rst_in_ready", in_ready, 0);
    check("rst_mem_we", mem_we, 0);
    check("rst_mem_addr", mem_addr, 0);
    check("rst_mem_wdata", mem_wdata, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_written", written, 0);
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;

    // Directed load with known packing.
    log_q.delete();
    do_start(8'h10, 9'd3);
    send(4'h1, 4'h1, 4'h2, 4'h3, 8'h00, 1'b0);
    send(4'h2, 4'h4, 4'h5, 4'h6, 8'h00, 1'b0);
    send(4'h3, 4'h7, 4'hF, 4'hC, 8'hA5, 1'b1);
    wait_done(100);
    check("t1_nwrites", log_q.size(), 3);
    if (log_q.size() == 3) begin
      check("t1_w0", log_q[0], 24'h101123);
      check("t1_w1", log_q[1], 24'h112456);
      check("t1_w2", log_q[2], 24'h1237A5);
    end
    check("t1_written", written, 3);

    // Back-pressure: memory stalls while four sets stream in.
    log_q.delete();
    rdy_force = 1'b0;
    do_start(8'h20, 9'd4);
    fork
      repeat (4) send_rand();
      begin
        repeat (12) @(posedge clk);
        @(negedge clk);
        check("bp_in_ready", in_ready, 0);
        check("bp_mem_we", mem_we, 1);
        check("bp_mem_addr", mem_addr, 8'h20);
        check("bp_nwrites", log_q.size(), 0);
        @(posedge clk); #1;
        rdy_force = 1'b1;
      end
    join
    wait_done(100);
    check("bp_total", log_q.size(), 4);
    for (int i = 0; i < 4 && i < log_q.size(); i++) check("bp_addr", log_q[i][23:16], 8'h20 + i);

    // Address wrap.
    log_q.delete();
    do_start(8'hFE, 9'd3);
    repeat (3) send_rand();
    wait_done(100);
    check("wrap_n", log_q.size(), 3);
    if (log_q.size() == 3) begin
      check("wrap_a0", log_q[0][23:16], 8'hFE);
      check("wrap_a1", log_q[1][23:16], 8'hFF);
      check("wrap_a2", log_q[2][23:16], 8'h00);
    end

    // Zero-length load, with in_valid asserted outside LOAD.
    log_q.delete();
    @(posedge clk); #1;
    in_valid = 1'b1; in_opcode = 4'h9;
    do_start(8'h33, 9'd0);
    @(negedge clk);
    check("zero_done", done, 1);
    check("zero_written", written, 0);
    repeat (3) @(posedge clk);
    #1 in_valid = 1'b0;
    check("zero_nwrites", log_q.size(), 0);

    // Reset in the middle of a load.
    log_q.delete();
    do_start(8'h40, 9'd5);
    repeat (2) send_rand();
    wait_writes(2);
    rdy_force = 1'b0;
    send_rand();
    @(posedge clk); #1;
    reset = 1'b1;
    #1;
    check("mid_mem_we", mem_we, 0);
    check("mid_in_ready", in_ready, 0);
    check("mid_busy", busy, 0);
    check("mid_done", done, 0);
    check("mid_written", written, 0);
    check("mid_mem_addr", mem_addr, 0);
    check("mid_mem_wdata", mem_wdata, 0);
    @(posedge clk); #1;
    reset = 1'b0;
    check("mid_nwrites", log_q.size(), 2);
    rdy_force = 1'b1;
    log_q.delete();
    do_start(8'h00, 9'd1);
    send(4'h5, 4'h6, 4'h7, 4'h8, 8'h00, 1'b0);
    wait_done(100);
    check("post_n", log_q.size(), 1);
    if (log_q.size() == 1) check("post_w0", log_q[0], 24'h005678);

    // Start during LOAD is ignored.
    log_q.delete();
    do_start(8'h50, 9'd3);
    send_rand();
    do_start(8'h90, 9'd7);
    repeat (2) send_rand();
    wait_done(100);
    check("ign_n", log_q.size(), 3);
    for (int i = 0; i < 3 && i < log_q.size(); i++) check("ign_addr", log_q[i][23:16], 8'h50 + i);
    check("ign_written", written, 3);

    // Randomized loads with random memory back-pressure.
    rand_rdy = 1;
    for (int l = 0; l < 6; l++) begin
      int c;
      c = $urandom_range(1, 10);
      do_start(8'($urandom), 9'(c));
      for (int k = 0; k < c; k++) begin
        repeat ($urandom_range(0, 2)) @(posedge clk);
        send_rand();
      end
      wait_done(400);
    end
    rand_rdy = 0;
    repeat (3) @(posedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule
